// File: rtl/mem_lock_arbiter.sv
// rtl/mem_lock_arbiter.sv - two-port external memory arbiter with shared address lock table
module mem_lock_arbiter #(
  parameter int LOCKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        main_mem_read_0,
  input  logic        main_mem_read_1,
  input  logic        main_mem_write_0,
  input  logic        main_mem_write_1,
  input  logic [15:0] mem_adr_0,
  input  logic [15:0] mem_adr_1,
  input  logic [15:0] mem_wdat_0,
  input  logic [15:0] mem_wdat_1,
  input  logic        lock_en_0,
  input  logic        lock_en_1,
  input  logic        unlock_en_0,
  input  logic        unlock_en_1,
  input  logic [9:0]  lock_adr_0,
  input  logic [9:0]  lock_adr_1,
  output logic        main_mem_ac_0,
  output logic        main_mem_ac_1,
  output logic [15:0] mem_rdat_0,
  output logic [15:0] mem_rdat_1,
  output logic        lock_ac_0,
  output logic        lock_ac_1,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_adr,
  output logic [15:0] ext_wdat,
  input  logic [15:0] ext_rdat,
  input  logic        ext_ready
);

  localparam int IW = $clog2(LOCKS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t state_q, state_d;

  logic [1:0]       rd, wr, lk, ul;
  logic [1:0][15:0] adr, wdat;
  logic [1:0][9:0]  ladr;

  assign rd   = {main_mem_read_1, main_mem_read_0};
  assign wr   = {main_mem_write_1, main_mem_write_0};
  assign lk   = {lock_en_1, lock_en_0};
  assign ul   = {unlock_en_1, unlock_en_0};
  assign adr  = {mem_adr_1, mem_adr_0};
  assign wdat = {mem_wdat_1, mem_wdat_0};
  assign ladr = {lock_adr_1, lock_adr_0};

  // Lock table: one valid bit, 10-bit address and owner per entry
  logic [LOCKS-1:0] lk_val_q;
  logic [LOCKS-1:0] lk_own_q;
  logic [9:0]       lk_adr_q [LOCKS];

  logic rr_q;                 // port that wins the next two-way contention
  logic win_q;                // port being served by the memory FSM
  logic [1:0] done_q;         // lock operation accepted last cycle, ack due now

  logic [1:0] blocked, elig;
  logic       grant, mem_win;

  logic [1:0]          hit_own, hit_oth, op_ul, op_lk, need, fill_ok, accept;
  logic [1:0][IW-1:0]  own_idx, fill_idx;
  logic [IW-1:0]       free0, free1;
  logic                has0, has1, lk_first;

  // A memory request is blocked while its low 10 address bits are locked by the other port
  always_comb begin
    blocked = '0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < LOCKS; i++)
        if (lk_val_q[i] && lk_adr_q[i] == adr[p][9:0] && lk_own_q[i] != 1'(p))
          blocked[p] = 1'b1;
  end

  assign elig    = (rd | wr) & ~blocked;
  assign mem_win = (elig == 2'b11) ? rr_q : elig[1];
  assign grant   = (state_q == S_IDLE) && (|elig);

  // Lock table lookup: own/other hits per port and the two lowest free entries
  always_comb begin
    hit_own = '0;
    hit_oth = '0;
    own_idx = '0;
    free0   = '0;
    free1   = '0;
    has0    = 1'b0;
    has1    = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < LOCKS; i++)
        if (lk_val_q[i] && lk_adr_q[i] == ladr[p]) begin
          if (lk_own_q[i] == 1'(p)) begin
            hit_own[p] = 1'b1;
            own_idx[p] = IW'(i);
          end else begin
            hit_oth[p] = 1'b1;
          end
        end
    for (int i = 0; i < LOCKS; i++)
      if (!lk_val_q[i]) begin
        if (!has0) begin
          has0  = 1'b1;
          free0 = IW'(i);
        end else if (!has1) begin
          has1  = 1'b1;
          free1 = IW'(i);
        end
      end
  end

  // Unlock takes precedence over lock on one port; nothing is re-accepted while its ack is due
  assign op_ul    = ul & ~done_q;
  assign op_lk    = lk & ~ul & ~done_q;
  assign need     = op_lk & ~hit_own & ~hit_oth;
  assign lk_first = (need == 2'b11) ? rr_q : need[1];

  // Allocate free entries: pointer winner takes the lowest, the other port the next one
  always_comb begin
    fill_ok  = '0;
    fill_idx = '0;
    if (need[lk_first]) begin
      fill_ok[lk_first]  = has0;
      fill_idx[lk_first] = free0;
    end
    if (need == 2'b11 && ladr[0] != ladr[1]) begin
      fill_ok[~lk_first]  = has1;
      fill_idx[~lk_first] = free1;
    end
  end

  assign accept = op_ul | (op_lk & (hit_own | fill_ok));

  // Commit lock table changes and remember which ports owe an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_val_q <= '0;
      lk_own_q <= '0;
      for (int i = 0; i < LOCKS; i++) lk_adr_q[i] <= '0;
      done_q   <= '0;
    end else begin
      done_q <= accept;
      for (int p = 0; p < 2; p++) begin
        if (op_ul[p] && hit_own[p]) lk_val_q[own_idx[p]] <= 1'b0;
        if (fill_ok[p]) begin
          lk_val_q[fill_idx[p]] <= 1'b1;
          lk_adr_q[fill_idx[p]] <= ladr[p];
          lk_own_q[fill_idx[p]] <= 1'(p);
        end
      end
    end
  end

  // Round-robin pointer moves to the loser after each memory grant or lock contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                rr_q <= 1'b0;
    else if (grant)           rr_q <= ~mem_win;
    else if (need == 2'b11)   rr_q <= ~lk_first;
  end

  // Memory FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Memory FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant) state_d = S_ACCESS;
      S_ACCESS: if (ext_ready) state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Memory FSM outputs; acks are dropped if the request was withdrawn
  always_comb begin
    ext_req       = (state_q == S_ACCESS);
    main_mem_ac_0 = (state_q == S_ACK) && !win_q && (rd[0] | wr[0]);
    main_mem_ac_1 = (state_q == S_ACK) &&  win_q && (rd[1] | wr[1]);
    lock_ac_0     = done_q[0] && (lk[0] | ul[0]);
    lock_ac_1     = done_q[1] && (lk[1] | ul[1]);
  end

  // Capture the winner's access on grant and its read data on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_adr    <= '0;
      ext_we     <= 1'b0;
      ext_wdat   <= '0;
      win_q      <= 1'b0;
      mem_rdat_0 <= '0;
      mem_rdat_1 <= '0;
    end else begin
      if (grant) begin
        ext_adr  <= adr[mem_win];
        ext_we   <= wr[mem_win];
        ext_wdat <= wdat[mem_win];
        win_q    <= mem_win;
      end
      if (state_q == S_ACCESS && ext_ready && !ext_we) begin
        if (win_q) mem_rdat_1 <= ext_rdat;
        else       mem_rdat_0 <= ext_rdat;
      end
    end
  end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// tb/tb_mem_lock_arbiter.sv - directed scoreboard bench for mem_lock_arbiter
module tb_mem_lock_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        main_mem_read_0, main_mem_read_1, main_mem_write_0, main_mem_write_1;
  logic [15:0] mem_adr_0, mem_adr_1, mem_wdat_0, mem_wdat_1;
  logic        lock_en_0, lock_en_1, unlock_en_0, unlock_en_1;
  logic [9:0]  lock_adr_0, lock_adr_1;
  logic        main_mem_ac_0, main_mem_ac_1, lock_ac_0, lock_ac_1;
  logic [15:0] mem_rdat_0, mem_rdat_1;
  logic        ext_req, ext_we, ext_ready;
  logic [15:0] ext_adr, ext_wdat, ext_rdat;
  logic        ready_en;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          port;
    logic [15:0] adr;
    logic        we;
    logic [15:0] wdat;
    logic [15:0] rdat;
  } exp_t;

  exp_t sb[$];

  mem_lock_arbiter #(.LOCKS(4)) dut (
    .clk(clk), .reset(reset),
    .main_mem_read_0(main_mem_read_0), .main_mem_read_1(main_mem_read_1),
    .main_mem_write_0(main_mem_write_0), .main_mem_write_1(main_mem_write_1),
    .mem_adr_0(mem_adr_0), .mem_adr_1(mem_adr_1),
    .mem_wdat_0(mem_wdat_0), .mem_wdat_1(mem_wdat_1),
    .lock_en_0(lock_en_0), .lock_en_1(lock_en_1),
    .unlock_en_0(unlock_en_0), .unlock_en_1(unlock_en_1),
    .lock_adr_0(lock_adr_0), .lock_adr_1(lock_adr_1),
    .main_mem_ac_0(main_mem_ac_0), .main_mem_ac_1(main_mem_ac_1),
    .mem_rdat_0(mem_rdat_0), .mem_rdat_1(mem_rdat_1),
    .lock_ac_0(lock_ac_0), .lock_ac_1(lock_ac_1),
    .ext_req(ext_req), .ext_we(ext_we), .ext_adr(ext_adr), .ext_wdat(ext_wdat),
    .ext_rdat(ext_rdat), .ext_ready(ext_ready)
  );

  always #5 clk = ~clk;

  assign ext_ready = ext_req & ready_en;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    main_mem_read_0 = 0; main_mem_read_1 = 0; main_mem_write_0 = 0; main_mem_write_1 = 0;
    mem_adr_0 = 0; mem_adr_1 = 0; mem_wdat_0 = 0; mem_wdat_1 = 0;
    lock_en_0 = 0; lock_en_1 = 0; unlock_en_0 = 0; unlock_en_1 = 0;
    lock_adr_0 = 0; lock_adr_1 = 0;
    ext_rdat = 0;
    ready_en = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic drop_mem(input int port);
    if (port == 0) begin main_mem_read_0 = 0; main_mem_write_0 = 0; end
    else begin main_mem_read_1 = 0; main_mem_write_1 = 0; end
  endtask

  // Wait for the next external access, check it against the scoreboard head, finish it
  task automatic expect_access(input int budget);
    exp_t e;
    int   n;
    logic ac;
    n = 0;
    while (!ext_req && n < budget) begin step(); n++; end
    chk("ext_req_seen", 16'(ext_req), 16'd1);
    if (ext_req && sb.size() > 0) begin
      e = sb.pop_front();
      chk("ext_adr", ext_adr, e.adr);
      chk("ext_we", 16'(ext_we), 16'(e.we));
      if (e.we) chk("ext_wdat", ext_wdat, e.wdat);
      ext_rdat = e.rdat;
      n  = 0;
      ac = 1'b0;
      while (!ac && n < budget) begin
        step(); n++;
        ac = (e.port == 0) ? main_mem_ac_0 : main_mem_ac_1;
      end
      chk("mem_ack_seen", 16'(ac), 16'd1);
      if (!e.we) chk("mem_rdat", (e.port == 0) ? mem_rdat_0 : mem_rdat_1, e.rdat);
      step();
      drop_mem(e.port);
    end
  endtask

  // Issue one lock or unlock and expect its ack the following cycle
  task automatic do_lock(input int port, input logic [9:0] a, input logic unlock);
    if (port == 0) begin lock_adr_0 = a; lock_en_0 = !unlock; unlock_en_0 = unlock; end
    else begin lock_adr_1 = a; lock_en_1 = !unlock; unlock_en_1 = unlock; end
    step();
    chk("lock_ac", 16'((port == 0) ? lock_ac_0 : lock_ac_1), 16'd1);
    step();
    if (port == 0) begin lock_en_0 = 0; unlock_en_0 = 0; end
    else begin lock_en_1 = 0; unlock_en_1 = 0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    chk("rst_ext_req", 16'(ext_req), 16'd0);
    chk("rst_ext_adr", ext_adr, 16'h0000);
    chk("rst_mem_rdat_0", mem_rdat_0, 16'h0000);
    chk("rst_acks", 16'({main_mem_ac_0, main_mem_ac_1, lock_ac_0, lock_ac_1}), 16'd0);
    reset = 1'b0;

    // Single read with minimum latency
    sb.push_back('{0, 16'h0123, 1'b0, 16'h0000, 16'hBEEF});
    main_mem_read_0 = 1; mem_adr_0 = 16'h0123;
    step();
    chk("rd_ext_req_c1", 16'(ext_req), 16'd1);
    begin
      exp_t e;
      e = sb.pop_front();
      chk("rd_ext_adr", ext_adr, e.adr);
      chk("rd_ext_we", 16'(ext_we), 16'(e.we));
      ext_rdat = e.rdat;
      step();
      chk("rd_ext_req_c2", 16'(ext_req), 16'd0);
      chk("rd_ack_c2", 16'(main_mem_ac_0), 16'd1);
      chk("rd_rdat", mem_rdat_0, e.rdat);
    end
    step();
    main_mem_read_0 = 0;
    chk("rd_ack_c3", 16'(main_mem_ac_0), 16'd0);

    // Contention: both write together after reset
    do_reset();
    sb.push_back('{0, 16'h0010, 1'b1, 16'h1111, 16'h0000});
    sb.push_back('{1, 16'h0020, 1'b1, 16'h2222, 16'h0000});
    main_mem_write_0 = 1; mem_adr_0 = 16'h0010; mem_wdat_0 = 16'h1111;
    main_mem_write_1 = 1; mem_adr_1 = 16'h0020; mem_wdat_1 = 16'h2222;
    expect_access(10);
    expect_access(10);
    chk("wr_keeps_rdat_1", mem_rdat_1, 16'h0000);
    chk("sb_empty", 16'(sb.size()), 16'd0);

    // Lock blocking a read from the other port
    do_reset();
    do_lock(1, 10'h045, 1'b0);
    ext_rdat = 16'h5A5A;
    main_mem_read_0 = 1; mem_adr_0 = 16'h1045;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("blk_no_ext_req", 16'(ext_req), 16'd0);
    end
    lock_adr_1 = 10'h045; unlock_en_1 = 1;
    step();
    chk("blk_unlock_ac", 16'(lock_ac_1), 16'd1);
    chk("blk_ext_req_still_0", 16'(ext_req), 16'd0);
    step();
    unlock_en_1 = 0;
    chk("blk_ext_req_after", 16'(ext_req), 16'd1);
    chk("blk_ext_adr", ext_adr, 16'h1045);
    step();
    chk("blk_ack", 16'(main_mem_ac_0), 16'd1);
    chk("blk_rdat", mem_rdat_0, 16'h5A5A);
    step();
    main_mem_read_0 = 0;

    // Full table
    do_reset();
    for (int a = 1; a <= 4; a++) do_lock(0, 10'(a), 1'b0);
    lock_adr_1 = 10'h005; lock_en_1 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("full_no_ac_1", 16'(lock_ac_1), 16'd0);
    end
    lock_adr_0 = 10'h002; unlock_en_0 = 1;
    step();
    chk("full_unlock_ac_0", 16'(lock_ac_0), 16'd1);
    chk("full_still_no_ac_1", 16'(lock_ac_1), 16'd0);
    step();
    unlock_en_0 = 0;
    chk("full_ac_1", 16'(lock_ac_1), 16'd1);
    chk("full_entry1_valid", 16'(dut.lk_val_q[1]), 16'd1);
    chk("full_entry1_adr", 16'(dut.lk_adr_q[1]), 16'h0005);
    chk("full_entry1_own", 16'(dut.lk_own_q[1]), 16'd1);
    step();
    lock_en_1 = 0;

    // Simultaneous lock on the same address
    do_reset();
    lock_adr_0 = 10'h3FF; lock_en_0 = 1;
    lock_adr_1 = 10'h3FF; lock_en_1 = 1;
    step();
    chk("sim_ac_0", 16'(lock_ac_0), 16'd1);
    chk("sim_no_ac_1", 16'(lock_ac_1), 16'd0);
    step();
    lock_en_0 = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sim_1_waits", 16'(lock_ac_1), 16'd0);
      step();
    end
    lock_en_1 = 0;

    // Reset in the middle of an access
    do_reset();
    do_lock(0, 10'h010, 1'b0);
    ready_en = 0;
    main_mem_read_1 = 1; mem_adr_1 = 16'h0200;
    step();
    step();
    chk("mid_ext_req_before", 16'(ext_req), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_ext_req", 16'(ext_req), 16'd0);
    chk("mid_acks", 16'({main_mem_ac_0, main_mem_ac_1, lock_ac_0, lock_ac_1}), 16'd0);
    chk("mid_table_empty", 16'(dut.lk_val_q), 16'd0);
    chk("mid_ext_adr", ext_adr, 16'h0000);
    main_mem_read_1 = 0;
    ready_en = 1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_ack_after", 16'({main_mem_ac_1, ext_req}), 16'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_lock_arbiter.md
MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

Interface
REQ-001 SHALL have parameter LOCKS, default 4, meaning number of lock-table entries (power of two, 2..8).
REQ-002 SHALL have a single clock and a reset that is asynchronous and active-high.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock
- reset  in  1  async active-high reset
- main_mem_read_0 / main_mem_read_1  in  1  read request, per core
- main_mem_write_0 / main_mem_write_1  in  1  write request, per core
- mem_adr_0 / mem_adr_1  in  16  access address
- mem_wdat_0 / mem_wdat_1  in  16  write data
- lock_en_0 / lock_en_1  in  1  lock request
- unlock_en_0 / unlock_en_1  in  1  unlock request
- lock_adr_0 / lock_adr_1  in  10  lock address
- main_mem_ac_0 / main_mem_ac_1  out  1  access-complete pulse
- mem_rdat_0 / mem_rdat_1  out  16  read data
- lock_ac_0 / lock_ac_1  out  1  lock/unlock-complete pulse
- ext_req  out  1  external memory request
- ext_we  out  1  external write enable
- ext_adr  out  16  external address
- ext_wdat  out  16  external write data
- ext_rdat  in  16  external read data
- ext_ready  in  1  external access done

Function
REQ-004 SHALL hold each request (read, write, lock_en, unlock_en) level-high until the matching ack pulse; requesters SHALL drop or change the request in the cycle after the ack.
REQ-005 SHALL treat read and write asserted together on one port as a write.
REQ-006 SHALL run a memory FSM with states IDLE, ACCESS and ACK.
REQ-007 SHALL, in IDLE, select one eligible memory request per cycle; a port with a pending request is eligible unless mem_adr_n[9:0] matches a valid lock entry owned by the other port.
REQ-008 SHALL resolve two eligible requests by a round-robin pointer; the pointer resets to port 0 and toggles to the non-winning port after every grant.
REQ-009 SHALL, on grant, register ext_adr, ext_we and ext_wdat from the winner, assert ext_req from the next cycle, and enter ACCESS.
REQ-010 SHALL, in ACCESS, hold ext_req and the ext_* outputs stable until ext_ready=1 is sampled; it SHALL then deassert ext_req, capture ext_rdat into mem_rdat_n of the winner, and enter ACK.
REQ-011 SHALL, in ACK, pulse main_mem_ac_n of the winner for exactly one cycle and return to IDLE; the minimum latency is request at cycle 0, ext_req at cycle 1, ack at cycle 2 (ext_ready=1 at cycle 1).
REQ-012 SHALL keep mem_rdat_n unchanged except on a read completion for that port; for writes, mem_rdat_n keeps its old value.
REQ-013 SHALL give each lock entry a valid bit, a 10-bit address and a 1-bit owner.
REQ-014 SHALL process lock and unlock requests independently of the memory FSM, at most one lock operation per port per cycle, and complete each with a one-cycle lock_ac_n pulse in the cycle after acceptance.
REQ-015 SHALL handle lock_en_n as follows:
- address held by the same port: ack with no table change;
- address held by the other port: wait, no ack;
- address not held and a free entry exists: fill the lowest free entry, owner n, then ack;
- table full: wait, no ack.
REQ-016 SHALL, on unlock_en_n, clear the entry matching lock_adr_n if owned by port n and always ack; unlocking an address that is absent or owned by the other port is a no-op plus ack.
REQ-017 SHALL, when both ports request a lock on the same free address in the same cycle, grant the port chosen by the round-robin pointer; the loser then sees the address as held and waits.
REQ-018 SHALL, when both ports request locks on different addresses with only one free entry, give the entry to the pointer winner; the other port waits.
REQ-019 SHALL apply a lock or unlock committed in cycle t to eligibility checks from cycle t+1.
REQ-020 SHALL suppress the ack of a request that is withdrawn before its ack; a lock or unlock already committed to the table stays committed.

Reset
REQ-021 SHALL, on reset assertion at any time (including mid-ACCESS), immediately force: FSM=IDLE, all lock valid bits=0, round-robin pointer=port 0, ext_req=0, ext_we=0, ext_adr=0, ext_wdat=0, all main_mem_ac_n=0, all lock_ac_n=0, all mem_rdat_n=0.
REQ-022 SHALL abandon any in-flight external access on reset, with no ack generated.

Verification
REQ-023 SHALL cover the single read: port 0 reads adr 0x0123, ext_ready=1 at the first ext_req cycle, ext_rdat=0xBEEF -> main_mem_ac_0 pulses at cycle 2 with mem_rdat_0=0xBEEF, and ext_req is high for exactly 1 cycle.
REQ-024 SHALL cover contention: both ports write in the same cycle after reset -> port 0 is served first and port 1 is served next, with ext_adr/ext_wdat matching port 1 during its ACCESS.
REQ-025 SHALL cover lock blocking: port 1 locks 0x045 (lock_ac_1 one cycle later), then port 0 reads 0x1045 -> no ext_req until port 1 unlocks 0x045, then ext_req the next cycle.
REQ-026 SHALL cover a full table: with LOCKS=4, port 0 locks 0x001..0x004, then port 1 locks 0x005 -> no lock_ac_1 until port 0 unlocks 0x002, after which lock_ac_1 is asserted and 0x005 fills entry 1.
REQ-027 SHALL cover the simultaneous lock: both ports lock 0x3FF in one cycle with the pointer at port 0 -> only lock_ac_0 pulses, and port 1 waits.
REQ-028 SHALL cover reset mid-access: reset asserted during ACCESS with ext_ready=0 -> ext_req=0 and all acks=0 immediately, lock table empty, and no ack afterwards.
